// File: rtl/ldst_pkg.sv
// ldst_pkg: shared types and constants for the load/store unit.
//   state_e         : FSM state encoding (IDLE, REQ, DONE)
//   size_e          : access size encoding on the 'size' port (0 = word, 1 = byte)
//   LDST_TIMEOUT_DEF: default bus-wait limit used when LDST_TIMEOUT_EN is defined
package ldst_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic {
        SIZE_WORD = 1'b0,
        SIZE_BYTE = 1'b1
    } size_e;

    localparam int unsigned LDST_TIMEOUT_DEF = 16;

endpackage : ldst_pkg

// File: rtl/ldst_align.sv
// ldst_align: purely combinational lane handling for the load/store unit.
//   is_load   in  1   1 = load, 0 = store
//   size      in  1   access size (size_e)
//   addr_lo   in  2   byte offset within the word
//   wdata     in  32  raw store data
//   mem_rdata in  32  raw bus read data
//   st_data   out 32  lane-steered store data
//   be        out 4   byte enables
//   ld_data   out 32  extracted, zero-extended load data (little-endian)
module ldst_align
    import ldst_pkg::*;
(
    input  logic        is_load,
    input  size_e       size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_rdata,
    output logic [31:0] st_data,
    output logic [3:0]  be,
    output logic [31:0] ld_data
);

    logic [7:0] rd_byte;

    always_comb begin
        st_data = wdata;
        be      = 4'b1111;
        if (!is_load && size == SIZE_BYTE) begin
            st_data = {4{wdata[7:0]}};
            be      = 4'b0001 << addr_lo;
        end
    end

    always_comb begin
        rd_byte = mem_rdata[7:0];
        case (addr_lo)
            2'd0: rd_byte = mem_rdata[7:0];
            2'd1: rd_byte = mem_rdata[15:8];
            2'd2: rd_byte = mem_rdata[23:16];
            2'd3: rd_byte = mem_rdata[31:24];
            default: rd_byte = mem_rdata[7:0];
        endcase
    end

    always_comb begin
        ld_data = mem_rdata;
        if (size == SIZE_BYTE) begin
            ld_data = {24'b0, rd_byte};
        end
    end

endmodule : ldst_align

// File: rtl/ldst_unit.sv
// ldst_unit: single-outstanding load/store sequencer between the datapath
// controller and a req/ack memory bus.
//   clk, rst (async, active-high)
//   start, is_load, size, addr, wdata       : request from datapath
//   mem_req, mem_we, mem_addr, mem_wdata,
//   mem_be, mem_ack, mem_rdata              : memory bus
//   busy, done, rdata, align_err, bus_err   : status / result
// Optional feature: define LDST_TIMEOUT_EN to abort a bus cycle that waits
// TIMEOUT_CYCLES cycles without mem_ack (bus_err=1). Without it REQ waits
// indefinitely and bus_err is tied low.
module ldst_unit
    import ldst_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = LDST_TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_load,
    input  logic        size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        align_err,
    output logic        bus_err
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("ldst_unit: TIMEOUT_CYCLES must be at least 1");
    end

    state_e      state_q, state_d;
    logic        ld_q;
    size_e       size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        align_err_q;
    logic        bus_err_q;
    logic        misaligned;
    logic        timeout;

    logic [31:0] st_data;
    logic [3:0]  be;
    logic [31:0] ld_data;

    ldst_align u_align (
        .is_load   (ld_q),
        .size      (size_q),
        .addr_lo   (addr_q[1:0]),
        .wdata     (wdata_q),
        .mem_rdata (mem_rdata),
        .st_data   (st_data),
        .be        (be),
        .ld_data   (ld_data)
    );

    assign misaligned = (size_e'(size) == SIZE_WORD) && (addr[1:0] != 2'b00);

`ifdef LDST_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] cnt_q;

    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (state_q == ST_IDLE) begin
            cnt_q <= '0;
        end else if (state_q == ST_REQ && !mem_ack && !timeout) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = misaligned ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                // ack takes priority over a coincident timeout
                if (mem_ack || timeout) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ld_q        <= 1'b0;
            size_q      <= SIZE_WORD;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            align_err_q <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        ld_q        <= is_load;
                        size_q      <= size_e'(size);
                        addr_q      <= addr;
                        wdata_q     <= wdata;
                        align_err_q <= misaligned;
                        bus_err_q   <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (mem_ack) begin
                        if (ld_q) begin
                            rdata_q <= ld_data;
                        end
                    end else if (timeout) begin
                        bus_err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Data and byte enables are only presented during the bus cycle so that
    // the bus sees zeros while idle, matching the reset values.
    assign mem_req   = (state_q == ST_REQ);
    assign mem_we    = (state_q == ST_REQ) && !ld_q;
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_wdata = (state_q == ST_REQ) ? st_data : '0;
    assign mem_be    = (state_q == ST_REQ) ? be : '0;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign rdata     = rdata_q;
    assign align_err = (state_q == ST_DONE) && align_err_q;
    assign bus_err   = (state_q == ST_DONE) && bus_err_q;

endmodule : ldst_unit
